// File: rtl/vga_timing_gen.sv
// VGA raster timing generator in the pixel clock domain. The raster starts only after the
// synchronised PLL lock flag has been held for LOCK_WAIT consecutive clocks.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int LOCK_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic       running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW      = $clog2(LOCK_WAIT + 1);

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_ACT_E  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_E  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] LOCK_TC = CW'(LOCK_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, lock_s_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic          ls_q, ls_d, fs_q, fs_d, run_q, run_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = '0;
    y_d     = '0;
    hs_d    = ~SYNC_POL;
    vs_d    = ~SYNC_POL;
    de_d    = 1'b0;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    run_d   = 1'b0;
    cnt_inc = (state_q == S_IDLE) ? CW'(1) : cnt_q + CW'(1);

    case (state_q)
      S_IDLE, S_WAIT: begin
        if (!lock_s_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == LOCK_TC) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          state_d = S_WAIT;
          cnt_d   = cnt_inc;
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d = S_IDLE;
        end else if (x_q == H_LAST) begin
          y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end else begin
          x_d = x_q + 10'd1;
          y_d = y_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // outputs are decoded from the next position so they stay aligned with x/y
    if (state_d == S_RUN) begin
      run_d = 1'b1;
      de_d  = ({1'b0, x_d} < H_ACT_E) && ({1'b0, y_d} < V_ACT_E);
      hs_d  = (({1'b0, x_d} >= HS_START) && ({1'b0, x_d} < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_d  = (({1'b0, y_d} >= VS_START) && ({1'b0, y_d} < VS_END)) ? SYNC_POL : ~SYNC_POL;
      ls_d  = (x_d == 10'd0);
      fs_d  = (x_d == 10'd0) && (y_d == 10'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      run_q   <= run_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign running     = run_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny SYNC_POL=1 instance share
// clock, reset and lock; both are compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       run, hs, vs, de, ls, fs;
    logic [9:0] x, y;
  } vec_t;

  logic       a_hsync, a_vsync, a_de, a_ls, a_fs, a_running;
  logic [9:0] a_x, a_y;
  logic       b_hsync, b_vsync, b_de, b_ls, b_fs, b_running;
  logic [9:0] b_x, b_y;
  vec_t       a_vec, b_vec;

  assign a_vec = {a_running, a_hsync, a_vsync, a_de, a_ls, a_fs, a_x, a_y};
  assign b_vec = {b_running, b_hsync, b_vsync, b_de, b_ls, b_fs, b_x, b_y};

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hsync(a_hsync), .vsync(a_vsync), .de(a_de), .x(a_x), .y(a_y),
    .line_start(a_ls), .frame_start(a_fs), .running(a_running)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .LOCK_WAIT(4)
  ) dut_b (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hsync(b_hsync), .vsync(b_vsync), .de(b_de), .x(b_x), .y(b_y),
    .line_start(b_ls), .frame_start(b_fs), .running(b_running)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_vec(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lock_wait(input int inst);
    return (inst == 0) ? 16 : 4;
  endfunction

  // Raster position is a pure function of clocks spent in RUN
  function automatic vec_t expect_out(input int inst, input bit run, input longint t);
    int ha, hf, hw, hb, va, vf, vw, vb, ht, vt;
    bit pol;
    longint xx, yy;
    vec_t e;
    if (inst == 0) begin
      ha = 640; hf = 16; hw = 96; hb = 48; va = 480; vf = 10; vw = 2; vb = 33; pol = 1'b0;
    end else begin
      ha = 8; hf = 2; hw = 3; hb = 3; va = 6; vf = 1; vw = 2; vb = 2; pol = 1'b1;
    end
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    e = '0;
    e.hs = ~pol;
    e.vs = ~pol;
    if (run) begin
      xx = t % ht;
      yy = (t / ht) % vt;
      e.run = 1'b1;
      e.x = 10'(xx);
      e.y = 10'(yy);
      e.de = (xx < ha) && (yy < va);
      e.hs = (xx >= ha + hf && xx < ha + hf + hw) ? pol : ~pol;
      e.vs = (yy >= va + vf && yy < va + vf + vw) ? pol : ~pol;
      e.ls = (xx == 0);
      e.fs = (xx == 0) && (yy == 0);
    end
    return e;
  endfunction

  bit     m_s1[2], m_s2[2], m_run[2];
  int     m_streak[2];
  longint m_t[2];
  bit     m_ls;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_run[i] = 0; m_streak[i] = 0; m_t[i] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          m_s1[i] = 0; m_s2[i] = 0; m_run[i] = 0; m_streak[i] = 0; m_t[i] = 0;
        end else begin
          m_ls = m_s2[i];
          m_s2[i] = m_s1[i];
          m_s1[i] = pll_locked;
          if (m_run[i]) begin
            if (m_ls) m_t[i]++;
            else begin
              m_run[i] = 0;
              m_streak[i] = 0;
            end
          end else if (m_ls) begin
            m_streak[i]++;
            if (m_streak[i] == lock_wait(i)) begin
              m_run[i] = 1;
              m_t[i] = 0;
              m_streak[i] = 0;
            end
          end else begin
            m_streak[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check_vec("a_cycle", a_vec, expect_out(0, m_run[0], m_t[0]));
    check_vec("b_cycle", b_vec, expect_out(1, m_run[1], m_t[1]));
  end

  initial begin
    int na, nb, k;
    rst = 1'b1;
    pll_locked = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_lit("a_reset_vec", 32'(a_vec), 32'({1'b0, 1'b1, 1'b1, 3'b000, 20'd0}));
    check_lit("b_reset_sync", {b_hsync, b_vsync}, 2'b00);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // bring-up latency: 2 sync flops plus LOCK_WAIT locked clocks
    na = 0; nb = 0;
    for (k = 1; k <= 100 && na == 0; k++) begin
      @(posedge clk); #1;
      if (b_running && nb == 0) nb = k;
      if (a_running) na = k;
    end
    check_lit("a_lock_delay", na, 18);
    check_lit("b_lock_delay", nb, 6);
    check_lit("a_first_run", {a_x, a_y, a_de, a_ls, a_fs}, {10'd0, 10'd0, 3'b111});

    repeat (656) @(posedge clk); #1;
    check_lit("a_hs_start", {a_x, a_hsync}, {10'd656, 1'b0});
    repeat (95) @(posedge clk); #1;
    check_lit("a_hs_last", {a_x, a_hsync}, {10'd751, 1'b0});
    @(posedge clk); #1;
    check_lit("a_hs_end", {a_x, a_hsync}, {10'd752, 1'b1});
    repeat (48) @(posedge clk); #1;
    check_lit("a_line2", {a_x, a_y, a_ls, a_fs, a_de}, {10'd0, 10'd1, 3'b101});

    // tiny instance: frame wrap, active-high syncs
    for (k = 0; k < 400 && !(b_x == 10'd15 && b_y == 10'd10); k++) begin
      @(posedge clk); #1;
    end
    check_lit("b_last_pixel", {b_x, b_y}, {10'd15, 10'd10});
    @(posedge clk); #1;
    check_lit("b_wrap", {b_x, b_y, b_fs, b_ls, b_vsync}, {10'd0, 10'd0, 3'b110});
    repeat (10) @(posedge clk); #1;
    check_lit("b_hs_active", {b_x, b_hsync}, {10'd10, 1'b1});
    for (k = 0; k < 400 && !(b_x == 10'd15 && b_y == 10'd6); k++) begin
      @(posedge clk); #1;
    end
    check_lit("b_vs_before", {b_y, b_vsync}, {10'd6, 1'b0});
    @(posedge clk); #1;
    check_lit("b_vs_edge", {b_x, b_y, b_vsync}, {10'd0, 10'd7, 1'b1});

    // lock loss: two sync clocks, then the FSM drops out on the third edge
    #1 pll_locked = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_lit("a_loss_still_run", a_running, 1);
    @(posedge clk); #1;
    check_lit("a_loss_idle", 32'(a_vec), 32'({1'b0, 1'b1, 1'b1, 3'b000, 20'd0}));
    repeat (4) @(posedge clk);

    // glitch while waiting for lock restarts the qualification count
    #1 pll_locked = 1'b1;
    repeat (10) @(posedge clk);
    #2 pll_locked = 1'b0;
    @(posedge clk);
    #2 pll_locked = 1'b1;
    na = 0;
    for (k = 1; k <= 100 && na == 0; k++) begin
      @(posedge clk); #1;
      if (a_running) na = k;
    end
    check_lit("a_relock_delay", na, 18);
    check_lit("a_relock_start", {a_x, a_y, a_fs}, {10'd0, 10'd0, 1'b1});

    // random lock activity, checked by the per-cycle model
    for (int c = 0; c < 30000; c++) begin
      @(posedge clk); #2;
      if (pll_locked) begin
        if ($urandom_range(0, 1999) == 0) pll_locked = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        pll_locked = 1'b1;
      end
    end
    pll_locked = 1'b1;

    // asynchronous reset in the middle of a clock high phase
    for (k = 0; k < 30000 && !(a_running && a_x == 10'd700 && a_y == 10'd20); k++) begin
      @(posedge clk); #1;
    end
    check_lit("a_reach_700_20", {a_x, a_y}, {10'd700, 10'd20});
    #2 rst = 1'b1;
    #1;
    check_lit("a_async_rst", 32'(a_vec), 32'({1'b0, 1'b1, 1'b1, 3'b000, 20'd0}));
    check_lit("b_async_rst", 32'(b_vec), 32'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
